// File: rtl/ce_paced_fifo.sv
// ce_paced_fifo: small synchronous FIFO that releases one sample per ce pulse
// into the slow multirate section. Writes arrive at full rate, and the output
// register holds its value between pops. Underflow and overflow are sticky.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     producer presents in_data this cycle
//   in_data      input sample (opaque)
//   in_ready     write accepted this cycle (combinational from ce and level)
//   ce           read strobe; pops at most one sample per high cycle
//   out_data     registered output sample, held between pops
//   out_valid    one-cycle pulse: out_data was loaded this cycle
//   level        number of stored entries
//   underflow    sticky: ce seen while empty
//   overflow     sticky: write attempted while in_ready low
//   clear_flags  synchronous clear of both sticky flags
module ce_paced_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  ce,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underflow,
    output logic                  overflow,
    input  logic                  clear_flags
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LEVEL_W = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = LEVEL_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;

    logic full;
    logic empty;
    logic wr;
    logic rd;
    logic unf_evt;
    logic ovf_evt;

    // Handshake: a pop in the same cycle frees a slot, so a full FIFO still
    // accepts a write when ce is high.
    always_comb begin
        full     = (level == FULL_LEVEL);
        empty    = (level == '0);
        in_ready = !full || ce;
        wr       = in_valid && in_ready;
        rd       = ce && !empty;
        unf_evt  = ce && empty;
        ovf_evt  = in_valid && !in_ready;
    end

    // Storage is not reset; stale contents are unreachable once level is 0.
    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            mem[wp] <= in_data;
        end
    end

    // Pointers, count, output register and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= rd;
            if (wr) begin
                wp <= wp + DEPTH_LOG2'(1);
            end
            // Read uses the pre-write state, so a write into an empty FIFO
            // is never popped in the same cycle.
            if (rd) begin
                out_data <= mem[rp];
                rp       <= rp + DEPTH_LOG2'(1);
            end
            case ({wr, rd})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
            // A new event in the clearing cycle wins over the clear.
            underflow <= unf_evt || (underflow && !clear_flags);
            overflow  <= ovf_evt || (overflow && !clear_flags);
        end
    end

endmodule

// File: tb/tb_ce_paced_fifo.sv
// Directed bench for ce_paced_fifo with a queue scoreboard: accepted writes
// are pushed and popped when an output pulse is expected.
module tb_ce_paced_fifo;

    localparam int unsigned DW    = 16;
    localparam int unsigned DL    = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          ce;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [DL:0]   level;
    logic          underflow;
    logic          overflow;
    logic          clear_flags;

    always #5 clk = ~clk;

    ce_paced_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .ce          (ce),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .level       (level),
        .underflow   (underflow),
        .overflow    (overflow),
        .clear_flags (clear_flags)
    );

    int unsigned   total_checks  = 0;
    int unsigned   passed_checks = 0;
    logic [DW-1:0] sb [$];
    int unsigned   m_level;
    logic [DW-1:0] m_out;
    logic          m_unf;
    logic          m_ovf;
    string         phase = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    endtask

    // One clock of stimulus with model update and full output check.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic c, input logic cf);
        logic m_ready;
        logic m_wr;
        logic m_rd;
        in_valid    = v;
        in_data     = d;
        ce          = c;
        clear_flags = cf;
        m_ready = (m_level != DEPTH) || c;
        m_wr    = v && m_ready;
        m_rd    = c && (m_level != 0);
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        @(posedge clk);
        m_unf   = (c && (m_level == 0)) || (m_unf && !cf);
        m_ovf   = (v && !m_ready) || (m_ovf && !cf);
        m_level = m_level + 32'(m_wr) - 32'(m_rd);
        if (m_wr) sb.push_back(d);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_rd));
        if (m_rd) m_out = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(m_out));
        chk("level", 32'(level), m_level);
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Two reset cycles with write and ce asserted to show reset priority.
    task automatic do_reset();
        rst         = 1'b1;
        in_valid    = 1'b1;
        in_data     = 16'hBEEF;
        ce          = 1'b1;
        clear_flags = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        m_level = 0;
        m_out   = '0;
        m_unf   = 1'b0;
        m_ovf   = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        ce = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        ce       = 1'b0;
    endtask

    initial begin
        logic c;
        logic v;
        logic rdy;
        int   sent;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; ce = 1'b0; clear_flags = 1'b0;
        m_level = 0; m_out = '0; m_unf = 1'b0; m_ovf = 1'b0;

        phase = "reset";
        do_reset();

        phase = "basic";
        cycle(1'b1, 16'd1, 1'b0, 1'b0);
        cycle(1'b1, 16'd2, 1'b0, 1'b0);
        cycle(1'b1, 16'd3, 1'b0, 1'b0);
        repeat (3) begin
            repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        cycle(1'b0, '0, 1'b0, 1'b0);

        phase = "fill";
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        phase = "full_pop";
        cycle(1'b1, 16'h1234, 1'b1, 1'b0);

        phase = "overflow";
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        phase = "drain";
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b0);

        phase = "underflow";
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("hold_1234", 32'(out_data), 32'h1234);
        cycle(1'b0, '0, 1'b0, 1'b1);

        phase = "empty_wr_ce";
        cycle(1'b1, 16'h0055, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("pop_55", 32'(out_data), 32'h55);
        cycle(1'b0, '0, 1'b0, 1'b0);

        phase = "wrap";
        sent = 0;
        for (int k = 0; k < 200 && sent < 20; k++) begin
            c   = ((k % 3) == 2);
            rdy = (m_level != DEPTH) || c;
            v   = ((k % 2) == 0) && rdy;
            cycle(v, 16'h0100 + 16'(sent), c, 1'b0);
            if (v) sent++;
        end
        total_checks++;
        assert (sent == 20) passed_checks++;
        else $error("FAIL wrap/sent: observed %0d expected 20", sent);

        phase = "mid_reset";
        do_reset();
        cycle(1'b1, 16'h00AA, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("pop_aa", 32'(out_data), 32'hAA);
        cycle(1'b0, '0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
